// File: rtl/sha256_padder.sv
// sha256_padder: turns a byte stream into 512-bit blocks with FIPS 180-4 padding for the sha256 core.
// Optional macro SHA256_PADDER_BLKCNT_EN adds blk_idx, the index of the block within its message.
module sha256_padder #(
    parameter int unsigned LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_keep,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
`ifdef SHA256_PADDER_BLKCNT_EN
    output logic         blk_last,
    output logic [63:0]  blk_idx
`else
    output logic         blk_last
`endif
);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_OUT,
        ST_EXTRA
    } state_e;

    state_e           state_q;
    logic [63:0][7:0] buf_q;
    logic [63:0][7:0] buf_c;
    logic [5:0]       ptr_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_c;
    logic [6:0]       n_c;
    logic             in_ready_q;
    logic             blk_valid_q;
    logic             blk_last_q;
    logic             tail_pending_q;
    logic             pad_pending_q;
    logic             beat_c;
    logic             xfer_c;

    assign beat_c = in_valid & in_ready_q;
    assign xfer_c = blk_valid_q & blk_ready;
    assign len_c  = in_keep ? (len_q + LEN_W'(8)) : len_q;
    assign n_c    = 7'(ptr_q) + 7'(in_keep);

    // Buffer contents after the current beat; byte k lives at index 63-k so byte 0 lands in [511:504].
    always_comb begin
        buf_c = buf_q;
        if (in_keep) begin
            buf_c[~ptr_q] = in_data;
        end
        if (in_last && !n_c[6]) begin
            buf_c[~n_c[5:0]] = 8'h80;
            if (n_c <= 7'd55) begin
                buf_c[7:0] = 64'(len_c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_FILL;
            buf_q          <= '0;
            ptr_q          <= '0;
            len_q          <= '0;
            in_ready_q     <= 1'b0;
            blk_valid_q    <= 1'b0;
            blk_last_q     <= 1'b0;
            tail_pending_q <= 1'b0;
            pad_pending_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    in_ready_q <= 1'b1;
                    if (beat_c) begin
                        buf_q <= buf_c;
                        if (in_keep) begin
                            ptr_q <= ptr_q + 6'd1;
                            len_q <= len_c;
                        end
                        if (in_last) begin
                            in_ready_q  <= 1'b0;
                            blk_valid_q <= 1'b1;
                            state_q     <= ST_OUT;
                            if (n_c <= 7'd55) begin
                                blk_last_q <= 1'b1;
                            end else begin
                                // Length does not fit: a tail block follows this one.
                                blk_last_q     <= 1'b0;
                                tail_pending_q <= 1'b1;
                                pad_pending_q  <= n_c[6];
                            end
                        end else if (in_keep && (ptr_q == 6'd63)) begin
                            in_ready_q  <= 1'b0;
                            blk_valid_q <= 1'b1;
                            blk_last_q  <= 1'b0;
                            state_q     <= ST_OUT;
                        end
                    end
                end
                ST_EXTRA: begin
                    buf_q          <= {(pad_pending_q ? 8'h80 : 8'h00), 440'd0, 64'(len_q)};
                    blk_valid_q    <= 1'b1;
                    blk_last_q     <= 1'b1;
                    tail_pending_q <= 1'b0;
                    pad_pending_q  <= 1'b0;
                    state_q        <= ST_OUT;
                end
                default: begin
                    if (xfer_c) begin
                        blk_valid_q <= 1'b0;
                        blk_last_q  <= 1'b0;
                        buf_q       <= '0;
                        if (tail_pending_q) begin
                            state_q <= ST_EXTRA;
                        end else begin
                            state_q    <= ST_FILL;
                            in_ready_q <= 1'b1;
                            if (blk_last_q) begin
                                len_q <= '0;
                                ptr_q <= '0;
                            end
                        end
                    end
                end
            endcase
        end
    end

`ifdef SHA256_PADDER_BLKCNT_EN
    logic [63:0] idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else if (xfer_c) begin
            idx_q <= blk_last_q ? 64'd0 : (idx_q + 64'd1);
        end
    end

    assign blk_idx = idx_q;
`endif

    assign in_ready  = in_ready_q;
    assign blk_valid = blk_valid_q;
    assign blk_data  = buf_q;
    assign blk_last  = blk_last_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: known padded blocks, block boundaries, backpressure and reset.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'h00;
    logic         in_keep = 1'b0;
    logic         in_last = 1'b0;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [511:0] blk_data;
    logic         blk_last;
`ifdef SHA256_PADDER_BLKCNT_EN
    logic [63:0]  blk_idx;
`endif

    sha256_padder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
`ifdef SHA256_PADDER_BLKCNT_EN
        .blk_last  (blk_last),
        .blk_idx   (blk_idx)
`else
        .blk_last  (blk_last)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [511:0] ABC_BLK   = {24'h616263, 8'h80, 416'h0, 64'h18};
    localparam logic [511:0] EMPTY_BLK = {8'h80, 440'h0, 64'h0};
    localparam logic [511:0] AB_BLK    = {16'h6162, 8'h80, 424'h0, 64'h10};
    localparam logic [511:0] A55_BLK   = {{55{8'h61}}, 8'h80, 64'h1B8};
    localparam logic [511:0] A56_BLK1  = {{56{8'h61}}, 8'h80, 56'h0};
    localparam logic [511:0] A56_BLK2  = {448'h0, 64'h1C0};
    localparam logic [511:0] SEQ_BLK1  = 512'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f;
    localparam logic [511:0] SEQ_BLK2  = {8'h80, 440'h0, 64'h200};

    typedef struct {
        logic [511:0] data;
        logic         last;
        logic [63:0]  idx;
        int           cyc;
    } blk_t;

    blk_t mon_b;
    blk_t got_b;
    blk_t got_b2;
    blk_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Record every block transfer; outputs are stable at the falling edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst && blk_valid && blk_ready) begin
            mon_b.data = blk_data;
            mon_b.last = blk_last;
`ifdef SHA256_PADDER_BLKCNT_EN
            mon_b.idx  = blk_idx;
`else
            mon_b.idx  = 64'd0;
`endif
            mon_b.cyc  = cyc;
            q.push_back(mon_b);
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic keep, input logic last);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_keep  = keep;
        in_last  = last;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 512'(in_ready), 512'(1));
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_keep  = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_fill(input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(d, 1'b1, (i == n - 1));
        end
        idle();
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #2 blk_ready = v;
    endtask

    task automatic set_rst(input logic v);
        @(posedge clk);
        #2 rst = v;
    endtask

    task automatic wait_blocks(input int n);
        int t = 0;
        while (q.size() < n && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        check("blk_count", 512'(q.size()), 512'(n));
    endtask

    task automatic pop_blk(output blk_t b);
        if (q.size() > 0) begin
            b = q.pop_front();
        end else begin
            b.data = '0;
            b.last = 1'b0;
            b.idx  = '1;
            b.cyc  = 0;
        end
    endtask

    task automatic expect_blk(input string tag, input logic [511:0] data, input logic last,
                              input logic [63:0] idx, output blk_t b);
        pop_blk(b);
        check({tag, "_data"}, b.data, data);
        check({tag, "_last"}, 512'(b.last), 512'(last));
`ifdef SHA256_PADDER_BLKCNT_EN
        check({tag, "_idx"}, 512'(b.idx), 512'(idx));
`else
        if (idx != b.idx) begin
            b.idx = idx;
        end
`endif
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", 512'(in_ready), 512'(0));
        check("rst_blk_valid", 512'(blk_valid), 512'(0));
        check("rst_blk_data", blk_data, 512'(0));
        check("rst_blk_last", 512'(blk_last), 512'(0));
        set_rst(1'b0);
        @(negedge clk);
        @(negedge clk);
        check("in_ready_after_rst", 512'(in_ready), 512'(1));
        set_ready(1'b1);

        // "abc" with a keep=0 beat in the middle that must be ignored
        q.delete();
        send_byte(8'h61, 1'b1, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        send_byte(8'h62, 1'b1, 1'b0);
        send_byte(8'h63, 1'b1, 1'b1);
        idle();
        wait_blocks(1);
        expect_blk("abc", ABC_BLK, 1'b1, 64'd0, got_b);

        // Empty message
        q.delete();
        send_byte(8'h00, 1'b0, 1'b1);
        idle();
        wait_blocks(1);
        expect_blk("empty", EMPTY_BLK, 1'b1, 64'd0, got_b);

        // "ab" closed by an empty tail beat
        q.delete();
        send_byte(8'h61, 1'b1, 1'b0);
        send_byte(8'h62, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b1);
        idle();
        wait_blocks(1);
        expect_blk("ab_tail", AB_BLK, 1'b1, 64'd0, got_b);

        // 55 bytes: padding and length just fit
        q.delete();
        send_fill(8'h61, 55);
        wait_blocks(1);
        expect_blk("a55", A55_BLK, 1'b1, 64'd0, got_b);

        // 56 bytes: length spills into a second block
        q.delete();
        send_fill(8'h61, 56);
        wait_blocks(2);
        expect_blk("a56_b1", A56_BLK1, 1'b0, 64'd0, got_b);
        expect_blk("a56_b2", A56_BLK2, 1'b1, 64'd1, got_b2);
        check("a56_extra_gap", 512'(got_b2.cyc - got_b.cyc), 512'(2));

        // 64 bytes 0x00..0x3F: raw block then pad-only block
        q.delete();
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(i), 1'b1, (i == 63));
        end
        idle();
        wait_blocks(2);
        expect_blk("seq_b1", SEQ_BLK1, 1'b0, 64'd0, got_b);
        expect_blk("seq_b2", SEQ_BLK2, 1'b1, 64'd1, got_b2);
        check("seq_extra_gap", 512'(got_b2.cyc - got_b.cyc), 512'(2));

        // Backpressure: block held stable for 5 cycles, input stalled
        set_ready(1'b0);
        q.delete();
        send_byte(8'h61, 1'b1, 1'b0);
        send_byte(8'h62, 1'b1, 1'b0);
        send_byte(8'h63, 1'b1, 1'b1);
        idle();
        check("bp_latency", 512'(blk_valid), 512'(1));
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 512'(blk_valid), 512'(1));
            check("bp_data", blk_data, ABC_BLK);
            check("bp_last", 512'(blk_last), 512'(1));
            check("bp_in_ready", 512'(in_ready), 512'(0));
            @(negedge clk);
        end
        set_ready(1'b1);
        wait_blocks(1);
        expect_blk("bp_abc", ABC_BLK, 1'b1, 64'd0, got_b);
        check("bp_in_ready_back", 512'(in_ready), 512'(1));

        // Reset while a block is waiting in OUT
        set_ready(1'b0);
        q.delete();
        send_byte(8'h61, 1'b1, 1'b0);
        send_byte(8'h62, 1'b1, 1'b1);
        idle();
        check("rst_pre_valid", 512'(blk_valid), 512'(1));
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 512'(blk_valid), 512'(0));
        check("rst_out_data", blk_data, 512'(0));
        check("rst_out_last", 512'(blk_last), 512'(0));
        check("rst_out_in_ready", 512'(in_ready), 512'(0));
        set_rst(1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_out_in_ready_back", 512'(in_ready), 512'(1));

        // Partial message discarded by reset; the next message starts from length 0
        set_ready(1'b1);
        send_byte(8'h71, 1'b1, 1'b0);
        idle();
        set_rst(1'b1);
        set_rst(1'b0);
        q.delete();
        send_byte(8'h61, 1'b1, 1'b0);
        send_byte(8'h62, 1'b1, 1'b0);
        send_byte(8'h63, 1'b1, 1'b1);
        idle();
        wait_blocks(1);
        expect_blk("post_rst_abc", ABC_BLK, 1'b1, 64'd0, got_b);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
